// File: rtl/sqrt_u32_chk_pkg.sv
// sqrt_u32_chk_pkg: widths, error code and delay-line entry type for the sqrt checker
package sqrt_u32_chk_pkg;
  localparam int X_W = 32;
  localparam int Y_W = 16;
  localparam int R_W = 17;
  localparam logic [R_W-1:0] R_ERR = 17'h1FFFF;
  typedef struct packed {
    logic vld;
    logic [X_W-1:0] x;
  } dly_ent_t;
endpackage

// File: rtl/sqrt_dly.sv
// sqrt_dly: LAT-deep {vld, x} shift line; only the valid bits are reset
module sqrt_dly
  import sqrt_u32_chk_pkg::*;
#(
  parameter int LAT = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  input  dly_ent_t din,
  output dly_ent_t dout
);
  logic [LAT-1:0] v;
  logic [X_W-1:0] d [LAT];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) v <= '0;
    else v <= LAT'({v, din.vld});
  always_ff @(posedge clk) begin
    d[0] <= din.x;
    for (int i = 1; i < LAT; i++) d[i] <= d[i-1];
  end
  assign dout = {v[LAT-1], d[LAT-1]};
endmodule

// File: rtl/sqrt_u32_chk.sv
// sqrt_u32_chk: aligns tapped sqrt operands with results, checks y*y <= x < (y+1)^2, keeps error stats
module sqrt_u32_chk
  import sqrt_u32_chk_pkg::*;
#(
  parameter int SQRT_LAT = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld_in,
  input  logic [X_W-1:0]   x_in,
  input  logic             vld_sqrt,
  input  logic [Y_W-1:0]   y_in,
  input  logic             clr,
  output logic             vld_out,
  output logic [X_W-1:0]   x_out,
  output logic [Y_W-1:0]   y_out,
  output logic [R_W-1:0]   r_out,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  output logic [X_W-1:0]   err_x,
  output logic             align_err
);
  dly_ent_t tap, tail;
  logic s1_vld;
  logic [X_W-1:0] s1_x, s1_p;
  logic [Y_W-1:0] s1_y;
  logic [X_W:0] d;
  logic e;
  assign tap = {vld_in, x_in};
  sqrt_dly #(.LAT(SQRT_LAT)) u_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (tap),
    .dout (tail)
  );
  // r = x - y*y is valid iff it is non-negative and at most 2y
  always_comb begin
    d = {1'b0, s1_x} - {1'b0, s1_p};
    e = d[X_W] | (d[X_W-1:0] > {{(X_W-Y_W-1){1'b0}}, s1_y, 1'b0});
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s1_vld <= 1'b0;
    else s1_vld <= vld_sqrt;
  always_ff @(posedge clk)
    if (vld_sqrt) begin
      s1_x <= tail.x;
      s1_y <= y_in;
      s1_p <= X_W'(y_in) * X_W'(y_in);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_out <= 1'b0;
      err <= 1'b0;
      x_out <= '0;
      y_out <= '0;
      r_out <= '0;
    end else begin
      vld_out <= s1_vld;
      err <= s1_vld & e;
      if (s1_vld) begin
        x_out <= s1_x;
        y_out <= s1_y;
        r_out <= e ? R_ERR : d[R_W-1:0];
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      err_sticky <= 1'b0;
      err_cnt <= '0;
      err_x <= '0;
      align_err <= 1'b0;
    end else if (clr) begin
      err_sticky <= 1'b0;
      err_cnt <= '0;
      err_x <= '0;
      align_err <= 1'b0;
    end else begin
      if (vld_sqrt != tail.vld) align_err <= 1'b1;
      if (vld_out & err) begin
        if (~&err_cnt) err_cnt <= err_cnt + CNT_W'(1);
        err_sticky <= 1'b1;
        if (!err_sticky) err_x <= x_out;
      end
    end
endmodule

// File: tb/tb_sqrt_u32_chk.sv
// tb_sqrt_u32_chk: directed self-checking bench for the sqrt result checker
module tb_sqrt_u32_chk;
  localparam int LAT = 16;
  localparam int CW = 8;
  logic clk = 0, rst_n = 0, vld_in = 0, vld_sqrt = 0, clr = 0;
  logic [31:0] x_in = 0;
  logic [15:0] y_in = 0;
  logic vld_out, err, err_sticky, align_err;
  logic [31:0] x_out, err_x;
  logic [15:0] y_out;
  logic [16:0] r_out;
  logic [CW-1:0] err_cnt;
  int pass_cnt = 0, total = 0, cyc = 0;
  bit sv[int];
  logic [15:0] sy[int];
  bit ov[int];
  bit oe[int];
  logic [16:0] orr[int];

  sqrt_u32_chk #(.SQRT_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .x_in(x_in), .vld_sqrt(vld_sqrt),
    .y_in(y_in), .clr(clr), .vld_out(vld_out), .x_out(x_out), .y_out(y_out),
    .r_out(r_out), .err(err), .err_sticky(err_sticky), .err_cnt(err_cnt),
    .err_x(err_x), .align_err(align_err)
  );

  always #5 clk = ~clk;

  // inputs for edge number cyc; outputs recorded 1 time unit after that edge
  task automatic tick(input bit v, input logic [31:0] x);
    vld_in = v;
    x_in = x;
    vld_sqrt = sv.exists(cyc);
    y_in = vld_sqrt ? sy[cyc] : 16'h0;
    @(posedge clk);
    #1;
    ov[cyc] = vld_out;
    orr[cyc] = r_out;
    oe[cyc] = err;
    cyc++;
  endtask

  task automatic issue(input logic [31:0] x, input logic [15:0] y);
    sv[cyc+LAT] = 1'b1;
    sy[cyc+LAT] = y;
    tick(1'b1, x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 32'h0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    int c = cyc, nv = 0;
    idle(100);
    for (int i = c; i < c + 100; i++) nv += int'(ov[i]);
    total++; if (nv != 0) $display("FAIL idle_vld got %0d valids want 0", nv); else pass_cnt++;
    total++; if (err_cnt !== 0) $display("FAIL rst_cnt got %0d want 0", err_cnt); else pass_cnt++;
    total++; if (err_sticky !== 0) $display("FAIL rst_sticky got %b want 0", err_sticky); else pass_cnt++;
    total++; if (err_x !== 0) $display("FAIL rst_err_x got %h want 0", err_x); else pass_cnt++;
    total++; if (align_err !== 0) $display("FAIL rst_align got %b want 0", align_err); else pass_cnt++;
  endtask

  task automatic test_golden();
    logic [31:0] xs[4] = '{32'd0, 32'd15, 32'd16, 32'hFFFFFFFF};
    logic [15:0] ys[4] = '{16'd0, 16'd3, 16'd4, 16'hFFFF};
    logic [16:0] rs[4] = '{17'd0, 17'd6, 17'd0, 17'h1FFFE};
    int c = cyc;
    for (int i = 0; i < 4; i++) issue(xs[i], ys[i]);
    idle(LAT + 4);
    total++; if (ov[c+LAT] !== 1'b0) $display("FAIL gold_early got %b want 0", ov[c+LAT]); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (ov[c+i+LAT+1] !== 1'b1 || orr[c+i+LAT+1] !== rs[i] || oe[c+i+LAT+1] !== 1'b0)
        $display("FAIL gold_%0d got v=%b r=%h e=%b want v=1 r=%h e=0", i, ov[c+i+LAT+1], orr[c+i+LAT+1], oe[c+i+LAT+1], rs[i]);
      else pass_cnt++;
    end
    total++; if (ov[c+LAT+5] !== 1'b0) $display("FAIL gold_late got %b want 0", ov[c+LAT+5]); else pass_cnt++;
    total++; if (err_cnt !== 0 || align_err !== 0) $display("FAIL gold_stats got cnt=%0d al=%b want 0 0", err_cnt, align_err); else pass_cnt++;
    total++; if (x_out !== 32'hFFFFFFFF || y_out !== 16'hFFFF) $display("FAIL gold_hold got x=%h y=%h want ffffffff ffff", x_out, y_out); else pass_cnt++;
  endtask

  task automatic test_error();
    int c = cyc;
    issue(32'd15, 16'd4);
    issue(32'd24, 16'd3);
    idle(LAT + 4);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (ov[c+i+LAT+1] !== 1'b1 || oe[c+i+LAT+1] !== 1'b1 || orr[c+i+LAT+1] !== 17'h1FFFF)
        $display("FAIL err_%0d got v=%b e=%b r=%h want v=1 e=1 r=1ffff", i, ov[c+i+LAT+1], oe[c+i+LAT+1], orr[c+i+LAT+1]);
      else pass_cnt++;
    end
    total++; if (err_cnt !== 2) $display("FAIL err_cnt got %0d want 2", err_cnt); else pass_cnt++;
    total++; if (err_x !== 32'd15) $display("FAIL err_x got %0d want 15", err_x); else pass_cnt++;
    total++; if (err_sticky !== 1'b1) $display("FAIL err_sticky got %b want 1", err_sticky); else pass_cnt++;
    do_clr();
    total++; if (err_cnt !== 0 || err_sticky !== 0 || err_x !== 0) $display("FAIL err_clr got cnt=%0d st=%b x=%h want 0 0 0", err_cnt, err_sticky, err_x); else pass_cnt++;
    // clr on the very edge that would count a new error
    issue(32'd15, 16'd4);
    idle(LAT + 1);
    do_clr();
    idle(3);
    total++; if (err_cnt !== 0 || err_sticky !== 0) $display("FAIL clr_wins got cnt=%0d st=%b want 0 0", err_cnt, err_sticky); else pass_cnt++;
  endtask

  task automatic test_align();
    int c = cyc;
    sv[c+LAT-1] = 1'b1;
    sy[c+LAT-1] = 16'd4;
    tick(1'b1, 32'd16);
    idle(LAT + 3);
    total++; if (align_err !== 1'b1) $display("FAIL align_early got %b want 1", align_err); else pass_cnt++;
    idle(5);
    total++; if (align_err !== 1'b1) $display("FAIL align_sticky got %b want 1", align_err); else pass_cnt++;
    do_clr();
    total++; if (align_err !== 1'b0) $display("FAIL align_clr got %b want 0", align_err); else pass_cnt++;
    sv[cyc+2] = 1'b1;
    sy[cyc+2] = 16'd0;
    idle(6);
    total++; if (align_err !== 1'b1) $display("FAIL align_orphan got %b want 1", align_err); else pass_cnt++;
    do_clr();
  endtask

  task automatic test_back_to_back();
    int c = cyc, nv = 0, bad = 0, y = 0;
    for (int x = 0; x < 65536; x++) begin
      while ((y + 1) * (y + 1) <= x) y++;
      issue(32'(x), 16'(y));
    end
    idle(LAT + 3);
    y = 0;
    for (int x = 0; x < 65536; x++) begin
      while ((y + 1) * (y + 1) <= x) y++;
      if (ov[c+x+LAT+1] !== 1'b1 || oe[c+x+LAT+1] !== 1'b0 || orr[c+x+LAT+1] !== 17'(x - y * y)) bad++;
    end
    for (int i = c; i < cyc; i++) nv += int'(ov[i]);
    total++; if (nv != 65536) $display("FAIL stream_count got %0d want 65536", nv); else pass_cnt++;
    total++; if (bad != 0) $display("FAIL stream_data got %0d bad results want 0", bad); else pass_cnt++;
    total++; if (err_cnt !== 0 || align_err !== 0) $display("FAIL stream_stats got cnt=%0d al=%b want 0 0", err_cnt, align_err); else pass_cnt++;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < (1 << CW) + 5; i++) issue(32'd5, 16'd3);
    idle(LAT + 4);
    total++; if (err_cnt !== {CW{1'b1}}) $display("FAIL sat_cnt got %h want %h", err_cnt, {CW{1'b1}}); else pass_cnt++;
    total++; if (err_x !== 32'd5 || err_sticky !== 1'b1) $display("FAIL sat_first got x=%0d st=%b want 5 1", err_x, err_sticky); else pass_cnt++;
    do_clr();
  endtask

  task automatic test_mid_reset();
    int c;
    for (int i = 0; i < LAT + 5; i++) issue(32'd1000 + 32'(i), 16'h00FF);
    total++; if (vld_out !== 1'b1 || err_cnt !== 3) $display("FAIL pre_rst got v=%b cnt=%0d want 1 3", vld_out, err_cnt); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total++;
    if (vld_out !== 0 || x_out !== 0 || y_out !== 0 || r_out !== 0 || err !== 0 || err_cnt !== 0 || err_sticky !== 0 || err_x !== 0 || align_err !== 0)
      $display("FAIL async_rst got v=%b x=%h y=%h r=%h e=%b cnt=%0d st=%b ex=%h al=%b want all 0", vld_out, x_out, y_out, r_out, err, err_cnt, err_sticky, err_x, align_err);
    else pass_cnt++;
    sv.delete();
    sy.delete();
    tick(1'b0, 32'h0);
    rst_n = 1'b1;
    c = cyc;
    idle(LAT + 3);
    begin
      int nv = 0;
      for (int i = c; i < cyc; i++) nv += int'(ov[i]);
      total++; if (nv != 0) $display("FAIL post_rst_vld got %0d valids want 0", nv); else pass_cnt++;
    end
    c = cyc;
    issue(32'd49, 16'd7);
    issue(32'd50, 16'd7);
    idle(LAT + 4);
    total++;
    if (ov[c+LAT+1] !== 1'b1 || orr[c+LAT+1] !== 17'd0 || ov[c+LAT+2] !== 1'b1 || orr[c+LAT+2] !== 17'd1)
      $display("FAIL restart got v=%b r=%h v=%b r=%h want 1 0 1 1", ov[c+LAT+1], orr[c+LAT+1], ov[c+LAT+2], orr[c+LAT+2]);
    else pass_cnt++;
    total++; if (align_err !== 1'b0 || err_cnt !== 0) $display("FAIL restart_stats got al=%b cnt=%0d want 0 0", align_err, err_cnt); else pass_cnt++;
  endtask

  initial begin
    idle(3);
    rst_n = 1'b1;
    test_reset();
    test_golden();
    test_error();
    test_align();
    test_back_to_back();
    test_saturate();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
